// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin sharing of one APU/FPU between several cores' APU ports.
// In-order tag FIFO routes each returned result to its issuing core.
module cv32e40p_apu_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 4,
  parameter int NARGS     = 3,
  parameter int WOP       = 6,
  parameter int NDSFLAGS  = 15,
  parameter int NUSFLAGS  = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  input  logic [NUM_REQ*NARGS*32-1:0]    operands_i,
  input  logic [NUM_REQ*WOP-1:0]         op_i,
  input  logic [NUM_REQ*NDSFLAGS-1:0]    flags_i,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [31:0]                    rdata_o,
  output logic [NUSFLAGS-1:0]            rflags_o,
  output logic                           fpu_req_o,
  input  logic                           fpu_gnt_i,
  output logic [NARGS*32-1:0]            fpu_operands_o,
  output logic [WOP-1:0]                 fpu_op_o,
  output logic [NDSFLAGS-1:0]            fpu_flags_o,
  input  logic                           fpu_rvalid_i,
  input  logic [31:0]                    fpu_rdata_i,
  input  logic [NUSFLAGS-1:0]            fpu_rflags_i,
  output logic [$clog2(MAX_OUTST):0]     outst_o,
  output logic                           err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;
  localparam int AW = NARGS * 32;

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] head;
  logic [IW:0]   idx;
  logic          found;
  logic          any;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          err;
  logic [IW-1:0] tags [MAX_OUTST];

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NUM_REQ)) begin
        idx = idx - (IW+1)'(NUM_REQ);
      end
      if (!found && req_i[idx]) begin
        found = 1'b1;
        sel   = idx[IW-1:0];
      end
    end
  end

  assign any   = |req_i;
  assign full  = (cnt == CW'(MAX_OUTST));
  assign empty = (cnt == '0);
  assign head  = tags[rptr];

  // no issue while full, even if a pop frees a slot this cycle
  assign fpu_req_o = any && !full && !rst_i;
  assign push      = fpu_req_o && fpu_gnt_i;
  assign pop       = fpu_rvalid_i && !empty && !rst_i;

  assign rdata_o  = fpu_rdata_i;
  assign rflags_o = fpu_rflags_i;
  assign outst_o  = cnt;
  assign err_o    = err;

  always_comb begin
    gnt_o          = '0;
    rvalid_o       = '0;
    fpu_operands_o = '0;
    fpu_op_o       = '0;
    fpu_flags_o    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == IW'(k)) begin
        gnt_o[k] = push;
        if (any) begin
          fpu_operands_o = operands_i[k*AW +: AW];
          fpu_op_o       = op_i[k*WOP +: WOP];
          fpu_flags_o    = flags_i[k*NDSFLAGS +: NDSFLAGS];
        end
      end
      if (head == IW'(k)) begin
        rvalid_o[k] = pop;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (sel == IW'(NUM_REQ-1)) ? '0 : sel + IW'(1);
        wptr   <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (fpu_rvalid_i && empty) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      tags[wptr] <= sel;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Bench for cv32e40p_apu_arbiter: directed scenarios plus random traffic
// checked against a queue-based reference model and a return scoreboard.
module tb_cv32e40p_apu_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int NA   = 3;
  localparam int WOP  = 6;
  localparam int NDS  = 15;
  localparam int NUS  = 5;
  localparam int AW   = NA * 32;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [N-1:0]           req_i;
  logic [N-1:0]           gnt_o;
  logic [N*AW-1:0]        operands_i;
  logic [N*WOP-1:0]       op_i;
  logic [N*NDS-1:0]       flags_i;
  logic [N-1:0]           rvalid_o;
  logic [31:0]            rdata_o;
  logic [NUS-1:0]         rflags_o;
  logic                   fpu_req_o;
  logic                   fpu_gnt_i;
  logic [AW-1:0]          fpu_operands_o;
  logic [WOP-1:0]         fpu_op_o;
  logic [NDS-1:0]         fpu_flags_o;
  logic                   fpu_rvalid_i;
  logic [31:0]            fpu_rdata_i;
  logic [NUS-1:0]         fpu_rflags_i;
  logic [$clog2(MAXO):0]  outst_o;
  logic                   err_o;

  cv32e40p_apu_arbiter #(
    .NUM_REQ(N), .MAX_OUTST(MAXO), .NARGS(NA),
    .WOP(WOP), .NDSFLAGS(NDS), .NUSFLAGS(NUS)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_i(req_i), .gnt_o(gnt_o),
    .operands_i(operands_i), .op_i(op_i), .flags_i(flags_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rflags_o(rflags_o),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
    .fpu_flags_o(fpu_flags_o),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i),
    .fpu_rflags_i(fpu_rflags_i),
    .outst_o(outst_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int     rr_m     = 0;
  int     outst_m  = 0;
  bit     err_m    = 1'b0;
  bit     pend_err = 1'b0;
  bit     popped   = 1'b0;
  int     sbq[$];
  logic [N-1:0] last_g = '0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int s);
    logic [N-1:0] v;
    v = '0;
    if (s >= 0) v[s] = 1'b1;
    return v;
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // monitor: outputs sampled 2 time units after the driving edge
  always @(negedge clk) begin
    int           s;
    bit           er;
    logic [N-1:0] erv;
    #2;
    s  = pick(req_i, rr_m);
    er = (s >= 0) && (outst_m < MAXO) && !rst_i;
    chk("fpu_req", 128'(fpu_req_o), 128'(er));
    chk("gnt", 128'(gnt_o), 128'((er && fpu_gnt_i) ? onehot(s) : '0));
    if (!rst_i) begin
      chk("operands", 128'(fpu_operands_o),
          128'((s >= 0) ? operands_i[s*AW +: AW] : '0));
      chk("op", 128'(fpu_op_o), 128'((s >= 0) ? op_i[s*WOP +: WOP] : '0));
      chk("flags", 128'(fpu_flags_o),
          128'((s >= 0) ? flags_i[s*NDS +: NDS] : '0));
    end
    chk("rdata", 128'(rdata_o), 128'(fpu_rdata_i));
    chk("rflags", 128'(rflags_o), 128'(fpu_rflags_i));
    erv    = '0;
    popped = 1'b0;
    if (!rst_i && fpu_rvalid_i) begin
      if (sbq.size() > 0) begin
        erv    = onehot(sbq.pop_front());
        popped = 1'b1;
      end else begin
        pend_err = 1'b1;
      end
    end
    chk("rvalid", 128'(rvalid_o), 128'(erv));
    chk("outst", 128'(outst_o), 128'(outst_m));
    chk("err", 128'(err_o), 128'(err_m));
  end

  // model commit for the coming clock edge
  always @(negedge clk) begin
    int s;
    bit hs;
    #4;
    if (rst_i) begin
      rr_m     = 0;
      outst_m  = 0;
      err_m    = 1'b0;
      pend_err = 1'b0;
      last_g   = '0;
      sbq.delete();
    end else begin
      s  = pick(req_i, rr_m);
      hs = (s >= 0) && (outst_m < MAXO) && fpu_gnt_i;
      last_g = hs ? onehot(s) : '0;
      if (hs) begin
        sbq.push_back(s);
        rr_m = (s + 1) % N;
      end
      outst_m = outst_m + int'(hs) - int'(popped);
      if (pend_err) err_m = 1'b1;
      pend_err = 1'b0;
    end
  end

  task automatic step(bit r, logic [N-1:0] q, bit g, bit rv, logic [31:0] d);
    @(negedge clk);
    rst_i        = r;
    req_i        = q;
    fpu_gnt_i    = g;
    fpu_rvalid_i = rv;
    fpu_rdata_i  = d;
    fpu_rflags_i = NUS'($urandom);
    for (int w = 0; w < N * NA; w++) operands_i[w*32 +: 32] = $urandom;
    op_i    = (N*WOP)'({$urandom, $urandom});
    flags_i = (N*NDS)'({$urandom, $urandom});
  endtask

  initial begin
    logic [N-1:0] q;
    bit           rv;
    rst_i        = 1'b1;
    req_i        = '1;
    fpu_gnt_i    = 1'b1;
    fpu_rvalid_i = 1'b0;
    fpu_rdata_i  = '0;
    fpu_rflags_i = '0;
    operands_i   = '0;
    op_i         = '0;
    flags_i      = '0;

    // reset with all cores requesting, then grants 0,1,2,3, then full
    step(1, 4'b1111, 1, 0, 0);
    step(1, 4'b1111, 1, 0, 0);
    repeat (5) step(0, 4'b1111, 1, 0, 0);
    step(0, 4'b1111, 0, 1, 32'h11);
    step(0, 4'b1111, 1, 0, 0);
    repeat (4) step(0, 4'b0000, 0, 1, 32'h22);
    // alternating pair with continuous push/pop
    step(0, 4'b1010, 1, 0, 0);
    repeat (5) step(0, 4'b1010, 1, 1, 32'h33);
    step(0, 4'b0000, 0, 1, 32'h44);
    // routing: core2 then core0, results 0xA then 0xB
    step(0, 4'b0100, 1, 0, 0);
    step(0, 4'b0001, 1, 0, 0);
    step(0, 4'b0000, 0, 1, 32'hA);
    step(0, 4'b0000, 0, 1, 32'hB);
    // push and pop together at occupancy 2
    step(0, 4'b0011, 1, 0, 0);
    step(0, 4'b0011, 1, 0, 0);
    step(0, 4'b0100, 1, 1, 32'hC);
    repeat (2) step(0, 4'b0000, 0, 1, 32'hD);
    // spurious return sets the sticky error; reset clears it
    step(0, 4'b0000, 0, 1, 32'hDEAD);
    repeat (3) step(0, 4'b0000, 0, 0, 0);
    step(1, 4'b0000, 0, 0, 0);
    step(0, 4'b0000, 0, 0, 0);
    // same-cycle push into an empty FIFO with a return is an error
    step(0, 4'b1000, 1, 1, 32'hE);
    step(0, 4'b0000, 0, 1, 32'hF);
    step(1, 4'b0000, 0, 0, 0);

    q = '0;
    for (int c = 0; c < 3000; c++) begin
      q  = (req_i & ~last_g) | N'($urandom_range(0, 15) & $urandom_range(0, 15));
      rv = (outst_m > 0) ? ($urandom_range(0, 2) == 0)
                         : ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 299) == 0), q, ($urandom_range(0, 3) != 0),
           rv, $urandom);
    end

    step(0, 4'b0000, 0, 0, 0);
    @(negedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
